game_top: RTL and testbench
===========================

Name: game_top

Overview:
- Top level of the first-person shooter demo; one 100 MHz clock domain.
- Receives a PS/2 keyboard stream and tracks the WASD key states.
- Moves an aiming crosshair once per video frame.
- Generates 640x480@60 VGA timing with 4-bit-per-channel RGB: sky/floor background with a red crosshair.

Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz to 25 MHz pixel enable).
- STEP, 2: crosshair pixels moved per frame per held key.
- CH_LEN, 8: crosshair half-arm length in pixels.
- PS2_TIMEOUT, 10000: idle clocks after which a partial PS/2 frame is discarded.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous active-high reset; named rst as in the codebase.
- PS2C  in  1  PS/2 clock, asynchronous, idle high.
- PS2D  in  1  PS/2 data, asynchronous, idle high.
- hs  out  1  horizontal sync, active low.
- vs  out  1  vertical sync, active low.
- r  out  4  red.
- g  out  4  green.
- b  out  4  blue.

Behaviour:
- Reset (asynchronous, rst=1):
  - all counters, shift registers and key flags cleared;
  - PS/2 synchronizer flops set to 1;
  - crosshair at (cx,cy)=(320,240);
  - outputs hs=1, vs=1, r=g=b=0.
- Pixel enable:
  - pe pulses one clk in every CLK_DIV;
  - divider counts 0..CLK_DIV-1, pe when count==CLK_DIV-1;
  - first pe is the 4th clk after reset release.
- VGA counters (advance only on pe):
  - hc 0..799, wraps to 0 and increments vc; vc 0..524, wraps to 0.
  - Horizontal: visible 0-639, front porch 640-655, sync 656-751 (hs=0), back porch 752-799.
  - Vertical: visible 0-479, front porch 480-489, sync 490-491 (vs=0), back porch 492-524.
  - Outputs hs, vs, r, g, b are registered on pe from the current hc/vc, so they lag the counters by one pixel and stay mutually aligned.
- Colour for a visible pixel (hc<640 and vc<480), priority order:
  - Crosshair, RGB=F,0,0: either (vc==cy and |hc-cx|<=CH_LEN), or (hc==cx and |vc-cy|<=CH_LEN).
  - Sky, RGB=4,8,F: vc<240.
  - Floor, RGB=6,6,6: otherwise.
  - Outside the visible area RGB=0.
- PS/2 receiver:
  - PS2C and PS2D each pass through a 2-flop synchronizer.
  - Falling edge = previous synced clock 1, current 0.
  - On each falling edge, shift in PS2D; 11 bits per frame: start(0), 8 data bits LSB first, odd parity, stop(1).
  - After the 11th bit, accept the code only if start=0, stop=1 and data plus parity has odd weight; the bit counter always resets afterwards.
  - An idle counter resets on every falling edge. When it reaches PS2_TIMEOUT, the bit counter clears, the partial frame is dropped and no code is emitted.
  - Lines stuck low therefore produce at most one edge and never a code.
- Scan-code decoder:
  - 0xF0 sets a break flag; 0xE0 is ignored.
  - Any other code sets the matching key flag to !break and then clears break.
  - Key flags: W=0x1D, A=0x1C, S=0x1B, D=0x23. Other codes change no flag but still clear break.
- Crosshair update:
  - Happens once per frame, on the pe where hc==0 and vc==480.
  - W: cy-=STEP. S: cy+=STEP. A: cx-=STEP. D: cx+=STEP.
  - Opposite keys both held cancel.
  - Results saturate to cx in [0,639] and cy in [0,479]; no wrap-around.
  - Unchanged at all other times, so it never changes mid-frame.
- Reset mid-operation: immediate return to the reset state; timing restarts at hc=vc=0.

Test Plan:
1. Reset pulse of 50 ns, then 50000 clk with PS2C=PS2D=0 -> hs falls at pe-count 657 (hc 656 registered), stays low 96 pixels (384 clk), period 3200 clk; vs stays 1; cx,cy stay 320,240; no scan code accepted.
2. Visible-pixel colour check -> pixel (0,0) RGB=4,8,F; pixel (0,300) RGB=6,6,6; pixel (320,240) RGB=F,0,0; pixels (328,240) and (320,232) red; pixel (329,240) sky/floor; hc=700 gives RGB=0.
3. Full frame run -> vs low exactly for lines 490-491; frame length 525x800 pe = 1,680,000 clk.
4. Send make 0x23 (D) with valid parity, run 3 frames -> cx=326; send F0,23 -> cx frozen.
5. Hold A for 200 frames -> cx saturates at 0. Hold W+S together -> cy unchanged.
6. Frame with bad parity, or 5 bits then idle > PS2_TIMEOUT, then valid 0x1D -> only 0x1D acts; cy decreases by 2 per frame.

Source files
------------

// File: rtl/game_top.sv
`default_nettype none
// ============================================================================
// Module  : game_top
// Purpose : Top level of the first-person shooter demo. Receives a PS/2
//           keyboard stream, tracks the WASD keys, moves an aiming crosshair
//           once per frame and renders 640x480@60 VGA with a sky/floor
//           background and a red crosshair.
// Ports   : clk        100 MHz system clock
//           rst        asynchronous active-high reset
//           PS2C/PS2D  PS/2 clock/data, asynchronous, idle high
//           hs/vs      horizontal/vertical sync, active low
//           r/g/b      4-bit colour channels
// Revision: 1.0 - initial release
// ============================================================================
module game_top #(
  parameter int CLK_DIV     = 4,
  parameter int STEP        = 2,
  parameter int CH_LEN      = 8,
  parameter int PS2_TIMEOUT = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic       hs,
  output logic       vs,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDLE_W = $clog2(PS2_TIMEOUT + 1);

  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] H_MAX    = 10'd799;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;
  localparam logic [9:0] V_MAX    = 10'd524;
  localparam logic [9:0] HORIZON  = 10'd240;
  localparam logic [9:0] CX_MAX   = 10'd639;
  localparam logic [9:0] CY_MAX   = 10'd479;
  localparam logic [9:0] CX_INIT  = 10'd320;
  localparam logic [9:0] CY_INIT  = 10'd240;

  localparam logic [11:0] RGB_RED   = 12'hF00;
  localparam logic [11:0] RGB_SKY   = 12'h48F;
  localparam logic [11:0] RGB_FLOOR = 12'h666;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  localparam logic [10:0]        CH_LEN_W = 11'(CH_LEN);
  localparam logic signed [11:0] STEP_S   = 12'(STEP);

  // --------------------------------------------------------------------------
  // Pixel enable
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             pe;

  assign pe = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     div_cnt <= '0;
    else if (pe) div_cnt <= '0;
    else         div_cnt <= div_cnt + 1'b1;
  end

  // --------------------------------------------------------------------------
  // VGA counters
  // --------------------------------------------------------------------------
  logic [9:0] hc;
  logic [9:0] vc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (pe) begin
      if (hc == H_MAX) begin
        hc <= '0;
        vc <= (vc == V_MAX) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pixel colour
  // --------------------------------------------------------------------------
  logic [9:0]  cx;
  logic [9:0]  cy;
  logic [10:0] hc_w, vc_w, cx_w, cy_w;
  logic        visible, on_h_arm, on_v_arm;
  logic [11:0] rgb_next;

  // One extra bit so the +CH_LEN window bounds cannot overflow.
  assign hc_w = {1'b0, hc};
  assign vc_w = {1'b0, vc};
  assign cx_w = {1'b0, cx};
  assign cy_w = {1'b0, cy};

  assign visible  = (hc < H_VIS) && (vc < V_VIS);
  assign on_h_arm = (vc == cy) && (hc_w + CH_LEN_W >= cx_w) && (hc_w <= cx_w + CH_LEN_W);
  assign on_v_arm = (hc == cx) && (vc_w + CH_LEN_W >= cy_w) && (vc_w <= cy_w + CH_LEN_W);

  always_comb begin
    rgb_next = 12'h000;
    if (visible) begin
      if (on_h_arm || on_v_arm) rgb_next = RGB_RED;
      else if (vc < HORIZON)    rgb_next = RGB_SKY;
      else                      rgb_next = RGB_FLOOR;
    end
  end

  // Syncs and colour share one register stage so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs        <= 1'b1;
      vs        <= 1'b1;
      {r, g, b} <= 12'h000;
    end else if (pe) begin
      hs        <= !((hc >= H_SYNC_S) && (hc <= H_SYNC_E));
      vs        <= !((vc >= V_SYNC_S) && (vc <= V_SYNC_E));
      {r, g, b} <= rgb_next;
    end
  end

  // --------------------------------------------------------------------------
  // PS/2 receiver
  // --------------------------------------------------------------------------
  logic c_meta, c_sync, c_prev;
  logic d_meta, d_sync;
  logic ps2_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      c_prev <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      c_meta <= PS2C;
      c_sync <= c_meta;
      c_prev <= c_sync;
      d_meta <= PS2D;
      d_sync <= d_meta;
    end
  end

  assign ps2_fall = c_prev & ~c_sync;

  logic [9:0]        shreg;
  logic [10:0]       frame_w;
  logic [3:0]        bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [7:0]        code;
  logic              code_stb;

  // Bits arrive LSB first: frame_w[0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign frame_w = {d_sync, shreg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      code     <= '0;
      code_stb <= 1'b0;
    end else begin
      code_stb <= 1'b0;
      if (ps2_fall) begin
        idle_cnt <= '0;
        shreg    <= frame_w[10:1];
        if (bit_cnt == 4'd10) begin
          bit_cnt  <= '0;
          code     <= frame_w[8:1];
          code_stb <= !frame_w[0] && frame_w[10] && (^frame_w[9:1]);
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (idle_cnt == IDLE_W'(PS2_TIMEOUT)) begin
        // Bus idle too long: drop any partial frame.
        bit_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scan-code decoder
  // --------------------------------------------------------------------------
  logic brk;
  logic key_w, key_a, key_s, key_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk   <= 1'b0;
      key_w <= 1'b0;
      key_a <= 1'b0;
      key_s <= 1'b0;
      key_d <= 1'b0;
    end else if (code_stb) begin
      if (code == SC_BREAK) begin
        brk <= 1'b1;
      end else if (code != SC_EXT) begin
        brk <= 1'b0;
        case (code)
          SC_W:    key_w <= !brk;
          SC_A:    key_a <= !brk;
          SC_S:    key_s <= !brk;
          SC_D:    key_d <= !brk;
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Crosshair position, updated only at the start of vertical blanking
  // --------------------------------------------------------------------------
  logic               frame_tick;
  logic signed [11:0] dx, dy, nx, ny;

  assign frame_tick = pe && (hc == 10'd0) && (vc == V_VIS);

  always_comb begin
    dx = 12'sd0;
    dy = 12'sd0;
    if (key_d && !key_a)      dx = STEP_S;
    else if (key_a && !key_d) dx = -STEP_S;
    if (key_s && !key_w)      dy = STEP_S;
    else if (key_w && !key_s) dy = -STEP_S;
    nx = $signed({2'b00, cx}) + dx;
    ny = $signed({2'b00, cy}) + dy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx <= CX_INIT;
      cy <= CY_INIT;
    end else if (frame_tick) begin
      if (nx < 12'sd0)                        cx <= 10'd0;
      else if (nx > $signed({2'b00, CX_MAX})) cx <= CX_MAX;
      else                                    cx <= nx[9:0];
      if (ny < 12'sd0)                        cy <= 10'd0;
      else if (ny > $signed({2'b00, CY_MAX})) cy <= CY_MAX;
      else                                    cy <= ny[9:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_game_top.sv
`default_nettype none
// ============================================================================
// Module  : tb_game_top
// Purpose : Self-checking bench for game_top. Expected values are queued when
//           stimulus is applied and compared when the design responds.
// Revision: 1.0 - initial release
// ============================================================================
module tb_game_top;

  localparam int CLK_DIV     = 4;
  localparam int STEP        = 2;
  localparam int CH_LEN      = 8;
  localparam int PS2_TIMEOUT = 10000;

  logic       clk;
  logic       rst;
  logic       ps2c;
  logic       ps2d;
  logic       hs;
  logic       vs;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;

  logic [9:0] f_hc;
  logic [9:0] f_vc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_codes  = 0;

  typedef struct {
    string tag;
    int    value;
  } exp_t;

  exp_t sb[$];

  int mcx, mcy;
  bit kw, ka, ks, kd;

  int px[12] = '{0, 0, 320, 328, 312, 320, 320, 329, 320, 700, 639, 0};
  int py[12] = '{0, 300, 240, 240, 240, 232, 248, 240, 231, 0, 479, 480};
  int pc[12] = '{'h48F, 'h666, 'hF00, 'hF00, 'hF00, 'hF00, 'hF00, 'h666, 'h48F, 0, 'h666, 0};

  game_top #(
    .CLK_DIV    (CLK_DIV),
    .STEP       (STEP),
    .CH_LEN     (CH_LEN),
    .PS2_TIMEOUT(PS2_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .PS2C(ps2c),
    .PS2D(ps2d),
    .hs  (hs),
    .vs  (vs),
    .r   (r),
    .g   (g),
    .b   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (dut.code_stb === 1'b1) n_codes <= n_codes + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic expect_val(input string tag, input int value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic observe(input int got);
    exp_t e;
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.tag   = "scoreboard_underflow";
      e.value = -1;
    end
    check(e.tag, got, e.value);
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic do_reset(input logic line);
    rst  = 1'b1;
    ps2c = line;
    ps2d = line;
    repeat (5) @(negedge clk);
    check("rst_hs", int'(hs), 1);
    check("rst_vs", int'(vs), 1);
    check("rst_rgb", int'({r, g, b}), 0);
    check("rst_cx", int'(dut.cx), 320);
    check("rst_cy", int'(dut.cy), 240);
    check("rst_hc_vc", int'({dut.hc, dut.vc}), 0);
    mcx = 320;
    mcy = 240;
    kw = 0; ka = 0; ks = 0; kd = 0;
    sb.delete();
    rst = 1'b0;
  endtask

  // Counts clocks until hs (or vs) reaches v, bounded.
  task automatic count_until(input bit sel_vs, input logic v, input int bound, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (((sel_vs ? vs : hs) !== v) && (n < bound));
  endtask

  // Loads the raster counters for exactly one pixel-enable edge.
  task automatic jump(input int x, input int y);
    int k;
    k = 0;
    @(negedge clk);
    while ((dut.pe !== 1'b1) && (k < 4 * CLK_DIV)) begin
      @(negedge clk);
      k++;
    end
    f_hc = 10'(x);
    f_vc = 10'(y);
    force dut.hc = f_hc;
    force dut.vc = f_vc;
    @(posedge clk);
    #1;
    release dut.hc;
    release dut.vc;
  endtask

  // Runs the raster into the frame-update point once and checks the result.
  task automatic frame();
    int dx, dy;
    dx = (kd && !ka) ? STEP : ((ka && !kd) ? -STEP : 0);
    dy = (ks && !kw) ? STEP : ((kw && !ks) ? -STEP : 0);
    mcx = clamp(mcx + dx, 0, 639);
    mcy = clamp(mcy + dy, 0, 479);
    expect_val("frame_cx", mcx);
    expect_val("frame_cy", mcy);
    jump(799, 479);
    repeat (3 * CLK_DIV) @(posedge clk);
    #1;
    observe(int'(dut.cx));
    observe(int'(dut.cy));
  endtask

  task automatic send_bits(input logic [10:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2d = fr[i];
      repeat (8) @(negedge clk);
      ps2c = 1'b0;
      repeat (16) @(negedge clk);
      ps2c = 1'b1;
      repeat (8) @(negedge clk);
    end
    ps2d = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] code, input bit bad_parity);
    logic par;
    par = bad_parity ? (^code) : (~^code);
    send_bits({1'b1, par, code, 1'b0}, 11);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n_lo, vs_lows, base;

    // Lines stuck low: sync timing, no codes, crosshair still.
    do_reset(1'b0);
    expect_val("hs_first_fall_clk", 657 * CLK_DIV);
    expect_val("hs_low_clk", 96 * CLK_DIV);
    expect_val("hs_period_clk", 800 * CLK_DIV);
    count_until(1'b0, 1'b0, 5000, n);
    observe(n);
    count_until(1'b0, 1'b1, 1000, n_lo);
    observe(n_lo);
    count_until(1'b0, 1'b0, 5000, n);
    observe(n_lo + n);
    vs_lows = 0;
    for (int i = 0; i < 6500; i++) begin
      @(posedge clk);
      #1;
      if (vs !== 1'b1) vs_lows++;
    end
    check("vs_idle_high", vs_lows, 0);
    check("stuck_bitcnt_cleared", int'(dut.bit_cnt), 0);
    check("stuck_no_codes", n_codes, 0);
    frame();

    // Colour of selected pixels.
    do_reset(1'b1);
    for (int i = 0; i < 12; i++) begin
      expect_val($sformatf("rgb_%0d_%0d", px[i], py[i]), pc[i]);
      jump(px[i], py[i]);
      observe(int'({r, g, b}));
    end

    // Vertical sync pulse position and width.
    expect_val("vs_fall_vc", 490);
    expect_val("vs_fall_hc", 1);
    expect_val("vs_low_clk", 2 * 800 * CLK_DIV);
    jump(799, 489);
    count_until(1'b1, 1'b0, 64, n);
    observe(int'(dut.vc));
    observe(int'(dut.hc));
    count_until(1'b1, 1'b1, 8000, n);
    observe(n);

    // D make (with an ignored E0 prefix), three frames, then break.
    do_reset(1'b1);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h23, 1'b0);
    kd = 1;
    repeat (3) frame();
    check("cx_after_3_frames", int'(dut.cx), 326);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h23, 1'b0);
    kd = 0;
    frame();

    // Hold A until saturation, then W+S together.
    send_byte(8'h1C, 1'b0);
    ka = 1;
    repeat (200) frame();
    check("cx_saturated", int'(dut.cx), 0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    ka = 0;
    send_byte(8'h1D, 1'b0);
    send_byte(8'h1B, 1'b0);
    kw = 1;
    ks = 1;
    frame();
    check("cy_w_s_cancel", int'(dut.cy), 240);

    // Bad parity and a truncated frame are dropped; a clean W then acts.
    do_reset(1'b1);
    base = n_codes;
    send_byte(8'h23, 1'b1);
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
    repeat (PS2_TIMEOUT + 200) @(negedge clk);
    check("codes_after_bad_frames", n_codes - base, 0);
    send_byte(8'h1D, 1'b0);
    check("codes_after_w", n_codes - base, 1);
    kw = 1;
    repeat (3) frame();
    check("cy_after_w", int'(dut.cy), 234);
    check("cx_after_w", int'(dut.cx), 320);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
